// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters plus the memory read-data pin.
interface dmem_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wren;
   logic [31:0] mem_rdata;

   logic        busy;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_addr, mem_wdata, mem_wren,
      input  mem_rdata,
      output busy
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_addr, mem_wdata, mem_wren,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU
// load/store path (port 0) and a second bus master (port 1).
//
// state | meaning
// IDLE  | no transaction; requests are sampled here
// ISSUE | command on the memory bus, winner's gnt high, mem_wren = we
// WAIT  | read in flight, counting down the memory read latency
module dmem_arbiter #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

   state_t     state;
   logic       last;
   logic       owner;
   logic [1:0] lat_cnt;
   logic       win;

   // Winner selection: a lone requester always wins, a tie goes to the port
   // that was not granted most recently.
   always_comb begin
      win = 1'b0;
      if (bus.m0_req && bus.m1_req) begin
         win = ~last;
      end else if (bus.m1_req) begin
         win = 1'b1;
      end
   end

   assign bus.busy = (state != IDLE);

   // Transaction sequencing with registered bus-side and requester-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         last          <= 1'b1;
         owner         <= 1'b0;
         lat_cnt       <= 2'd0;
         bus.mem_addr  <= 32'd0;
         bus.mem_wdata <= 32'd0;
         bus.mem_wren  <= 1'b0;
         bus.m0_gnt    <= 1'b0;
         bus.m1_gnt    <= 1'b0;
         bus.m0_rvalid <= 1'b0;
         bus.m1_rvalid <= 1'b0;
         bus.m0_rdata  <= 32'd0;
         bus.m1_rdata  <= 32'd0;
      end else begin
         bus.m0_gnt    <= 1'b0;
         bus.m1_gnt    <= 1'b0;
         bus.m0_rvalid <= 1'b0;
         bus.m1_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.m0_req || bus.m1_req) begin
                  state <= ISSUE;
                  owner <= win;
                  last  <= win;
                  if (win) begin
                     bus.mem_addr  <= bus.m1_addr;
                     bus.mem_wdata <= bus.m1_wdata;
                     bus.mem_wren  <= bus.m1_we;
                     bus.m1_gnt    <= 1'b1;
                  end else begin
                     bus.mem_addr  <= bus.m0_addr;
                     bus.mem_wdata <= bus.m0_wdata;
                     bus.mem_wren  <= bus.m0_we;
                     bus.m0_gnt    <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               bus.mem_wren <= 1'b0;
               if (bus.mem_wren) begin
                  state <= IDLE;
               end else begin
                  state   <= WAIT;
                  lat_cnt <= LAT_INIT;
               end
            end
            WAIT: begin
               if (lat_cnt == 2'd1) begin
                  state <= IDLE;
                  if (owner) begin
                     bus.m1_rdata  <= bus.mem_rdata;
                     bus.m1_rvalid <= 1'b1;
                  end else begin
                     bus.m0_rdata  <= bus.mem_rdata;
                     bus.m0_rvalid <= 1'b1;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with a 1-cycle memory and one
// with a 3-cycle memory, sharing clock and reset.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   dmem_arbiter_if ia ();
   dmem_arbiter_if ib ();

   dmem_arbiter #(.RD_LAT(1)) u_a (.clk(clk), .rst(rst), .bus(ia));
   dmem_arbiter #(.RD_LAT(3)) u_b (.clk(clk), .rst(rst), .bus(ib));

   always #5 clk = ~clk;

   // Memory with one edge of read latency.
   logic [31:0] mem_a [0:255];
   always @(posedge clk) begin
      if (ia.mem_wren) mem_a[ia.mem_addr[9:2]] <= ia.mem_wdata;
      ia.mem_rdata <= mem_a[ia.mem_addr[9:2]];
   end

   // Memory with three edges of read latency.
   logic [31:0] mem_b [0:255];
   logic [31:0] pipe_b1, pipe_b2;
   always @(posedge clk) begin
      if (ib.mem_wren) mem_b[ib.mem_addr[9:2]] <= ib.mem_wdata;
      pipe_b1      <= mem_b[ib.mem_addr[9:2]];
      pipe_b2      <= pipe_b1;
      ib.mem_rdata <= pipe_b2;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits for a grant on instance A; port is -1 when none arrives in time.
   task automatic wait_gnt(output int port);
      port = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ia.m0_gnt || ia.m1_gnt) begin
            check("single_gnt", {31'd0, ia.m0_gnt & ia.m1_gnt}, 32'd0);
            port = ia.m1_gnt ? 1 : 0;
            break;
         end
      end
      if (port < 0) check("gnt_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_rv(input int port, input logic [31:0] data);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ia.m0_rvalid || ia.m1_rvalid) begin
            seen = 1'b1;
            check("single_rvalid", {31'd0, ia.m0_rvalid & ia.m1_rvalid}, 32'd0);
            check("rvalid_port", ia.m1_rvalid ? 32'd1 : 32'd0, 32'(port));
            check("rdata", port == 1 ? ia.m1_rdata : ia.m0_rdata, data);
            break;
         end
      end
      if (!seen) check("rvalid_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int p;
      ia.m0_req = 0; ia.m0_we = 0; ia.m0_addr = 0; ia.m0_wdata = 0;
      ia.m1_req = 0; ia.m1_we = 0; ia.m1_addr = 0; ia.m1_wdata = 0;
      ib.m0_req = 0; ib.m0_we = 0; ib.m0_addr = 0; ib.m0_wdata = 0;
      ib.m1_req = 0; ib.m1_we = 0; ib.m1_addr = 0; ib.m1_wdata = 0;

      // Reset values
      tick(); tick();
      check("rst_mem_addr",  ia.mem_addr, 32'd0);
      check("rst_mem_wdata", ia.mem_wdata, 32'd0);
      check("rst_mem_wren",  {31'd0, ia.mem_wren}, 32'd0);
      check("rst_busy",      {31'd0, ia.busy}, 32'd0);
      check("rst_gnt",       {30'd0, ia.m1_gnt, ia.m0_gnt}, 32'd0);
      check("rst_rvalid",    {30'd0, ia.m1_rvalid, ia.m0_rvalid}, 32'd0);
      check("rst_m0_rdata",  ia.m0_rdata, 32'd0);
      check("rst_m1_rdata",  ia.m1_rdata, 32'd0);
      rst = 1'b0;

      // Port 0 write 0xDEADBEEF to 0x10
      ia.m0_req = 1; ia.m0_we = 1; ia.m0_addr = 32'h10; ia.m0_wdata = 32'hDEADBEEF;
      tick();
      check("wr_gnt0",  {31'd0, ia.m0_gnt}, 32'd1);
      check("wr_gnt1",  {31'd0, ia.m1_gnt}, 32'd0);
      check("wr_wren",  {31'd0, ia.mem_wren}, 32'd1);
      check("wr_addr",  ia.mem_addr, 32'h10);
      check("wr_wdata", ia.mem_wdata, 32'hDEADBEEF);
      check("wr_busy",  {31'd0, ia.busy}, 32'd1);
      ia.m0_req = 0;
      tick();
      check("wr_done_busy", {31'd0, ia.busy}, 32'd0);
      check("wr_done_wren", {31'd0, ia.mem_wren}, 32'd0);
      check("wr_no_rvalid", {31'd0, ia.m0_rvalid}, 32'd0);

      // Port 1 read of 0x10, RD_LAT=1
      ia.m1_req = 1; ia.m1_we = 0; ia.m1_addr = 32'h10;
      tick();
      check("rd1_gnt1", {31'd0, ia.m1_gnt}, 32'd1);
      check("rd1_wren", {31'd0, ia.mem_wren}, 32'd0);
      check("rd1_addr", ia.mem_addr, 32'h10);
      ia.m1_req = 0;
      tick();
      check("rd1_wait_rvalid", {31'd0, ia.m1_rvalid}, 32'd0);
      check("rd1_wait_busy",   {31'd0, ia.busy}, 32'd1);
      tick();
      check("rd1_rvalid", {31'd0, ia.m1_rvalid}, 32'd1);
      check("rd1_rdata",  ia.m1_rdata, 32'hDEADBEEF);
      check("rd1_m0_rvalid", {31'd0, ia.m0_rvalid}, 32'd0);
      check("rd1_busy",   {31'd0, ia.busy}, 32'd0);
      tick();
      check("rd1_rvalid_pulse", {31'd0, ia.m1_rvalid}, 32'd0);
      check("rd1_rdata_hold",   ia.m1_rdata, 32'hDEADBEEF);

      // Port 1 write 0x12345678 to unaligned 0x23 (address passes through)
      ia.m1_req = 1; ia.m1_we = 1; ia.m1_addr = 32'h23; ia.m1_wdata = 32'h12345678;
      tick();
      check("wr1_gnt1", {31'd0, ia.m1_gnt}, 32'd1);
      check("wr1_addr", ia.mem_addr, 32'h23);
      check("wr1_wren", {31'd0, ia.mem_wren}, 32'd1);
      ia.m1_req = 0; ia.m1_we = 0;
      tick();

      // Instance B: write then RD_LAT=3 read
      ib.m1_req = 1; ib.m1_we = 1; ib.m1_addr = 32'h10; ib.m1_wdata = 32'hCAFEF00D;
      tick();
      check("b_wr_gnt1", {31'd0, ib.m1_gnt}, 32'd1);
      ib.m1_req = 0;
      tick();
      ib.m0_req = 1; ib.m0_we = 0; ib.m0_addr = 32'h10;
      tick();
      check("b_rd_gnt0", {31'd0, ib.m0_gnt}, 32'd1);
      ib.m0_req = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("b_rd_busy",   {31'd0, ib.busy}, 32'd1);
         check("b_rd_rvalid", {31'd0, ib.m0_rvalid}, 32'd0);
      end
      tick();
      check("b_rd_rvalid_k4", {31'd0, ib.m0_rvalid}, 32'd1);
      check("b_rd_rdata",     ib.m0_rdata, 32'hCAFEF00D);
      check("b_rd_busy_end",  {31'd0, ib.busy}, 32'd0);

      // Both ports read continuously from reset: grants alternate 0,1,0,1
      rst = 1;
      tick();
      check("rst2_m1_rdata", ia.m1_rdata, 32'd0);
      rst = 0;
      ia.m0_req = 1; ia.m0_we = 0; ia.m0_addr = 32'h10;
      ia.m1_req = 1; ia.m1_we = 0; ia.m1_addr = 32'h20;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(p);
         check("alt_grant", 32'(p), 32'(i % 2));
         if (i == 3) ia.m0_req = 0;
         wait_rv(i % 2, (i % 2) ? 32'h12345678 : 32'hDEADBEEF);
      end

      // Port 1 alone, repeatedly granted; then port 0 wins the tie
      for (int i = 0; i < 3; i++) begin
         wait_gnt(p);
         check("solo_p1_grant", 32'(p), 32'd1);
         if (i == 2) ia.m0_req = 1;
         wait_rv(1, 32'h12345678);
      end
      wait_gnt(p);
      check("tie_after_solo", 32'(p), 32'd0);
      ia.m0_req = 0; ia.m1_req = 0;
      wait_rv(0, 32'hDEADBEEF);
      tick();

      // Reset overrides a pending request, then reset mid-WAIT drops the read
      rst = 1; ia.m1_req = 1;
      tick();
      check("rst_req_gnt",  {31'd0, ia.m1_gnt}, 32'd0);
      check("rst_req_busy", {31'd0, ia.busy}, 32'd0);
      rst = 0; ia.m1_req = 0;
      ia.m0_req = 1; ia.m0_we = 0; ia.m0_addr = 32'h10;
      tick();
      check("rw_gnt0", {31'd0, ia.m0_gnt}, 32'd1);
      ia.m0_req = 0;
      tick();
      check("rw_in_wait", {31'd0, ia.busy}, 32'd1);
      rst = 1;
      tick();
      check("rw_rvalid",   {31'd0, ia.m0_rvalid}, 32'd0);
      check("rw_rdata",    ia.m0_rdata, 32'd0);
      check("rw_busy",     {31'd0, ia.busy}, 32'd0);
      check("rw_mem_addr", ia.mem_addr, 32'd0);
      check("rw_wdata",    ia.mem_wdata, 32'd0);
      check("rw_wren",     {31'd0, ia.mem_wren}, 32'd0);
      rst = 0;
      tick();
      check("rw_no_late_rvalid", {31'd0, ia.m0_rvalid}, 32'd0);
      check("rw_rdata_after",    ia.m0_rdata, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
